booth_pp_accumulator: RTL
=========================

BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand width of the originating multiply.
REQ-002 SHALL have parameter NUM_TERMS, default DATA_WIDTH/2+1: number of partial-product terms per operation.
REQ-003 SHALL have parameter TERM_WIDTH, default 2*DATA_WIDTH: width of each term and of the product.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1: pp_bus holds a valid term set.
REQ-007 SHALL have port in_ready  output  1: block accepts a new term set.
REQ-008 SHALL have port pp_bus  input  NUM_TERMS*TERM_WIDTH: packed terms; term i occupies bits [i*TERM_WIDTH +: TERM_WIDTH].
REQ-009 SHALL have port out_valid  output  1: product is valid.
REQ-010 SHALL have port out_ready  input  1: consumer accepts the product.
REQ-011 SHALL have port product  output  TERM_WIDTH: sum of all terms.
REQ-012 SHALL have port busy  output  1: high in ACCUM state.

Function
REQ-013 SHALL treat each term as two's complement, already weighted (shifted) and sign-extended to TERM_WIDTH.
REQ-014 SHALL compute product = sum of all NUM_TERMS terms modulo 2^TERM_WIDTH; overflow wraps silently.
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready, SHALL register pp_bus, clear accumulator, clear term counter, go to ACCUM.
REQ-017 ACCUM: SHALL add exactly one term per cycle (term index = counter, 0 first) and increment the counter.
REQ-018 ACCUM: after adding term NUM_TERMS-1, SHALL go to DONE; in_ready=0 throughout ACCUM.
REQ-019 DONE: out_valid=1, product SHALL hold stable until out_valid&&out_ready; then go to IDLE.
REQ-020 Latency: out_valid SHALL rise exactly NUM_TERMS+1 cycles after the accepting edge.
REQ-021 in_valid while not in IDLE SHALL be ignored; pp_bus changes after acceptance SHALL NOT affect the result.
REQ-022 out_ready while not in DONE SHALL be ignored.
REQ-023 Throughput: a new set SHALL be accepted no earlier than the cycle after the output handshake (one operation per NUM_TERMS+2 cycles).
REQ-024 Counter width SHALL be $clog2(NUM_TERMS)+1; no wrap-around before NUM_TERMS.

Reset
REQ-025 On rst_n low, regardless of state, SHALL go to IDLE asynchronously, clearing accumulator, counter and registered terms.
REQ-026 Reset values: in_ready=1, out_valid=0, busy=0, product=0.
REQ-027 Reset mid-ACCUM or mid-DONE SHALL discard the operation; no out_valid pulse after deassertion.

Structure
REQ-028 Shared package booth_pkg SHALL hold the FSM state encoding and the NUM_TERMS/TERM_WIDTH derivation constants.
REQ-029 SHALL instantiate one sub-module pp_term_select: combinational mux returning term[counter] from the registered bus.
REQ-030 Accumulator adder SHALL be a single TERM_WIDTH-bit adder; no carry-save tree.

Verification (DATA_WIDTH=8, NUM_TERMS=5, TERM_WIDTH=16)
REQ-031 All terms 0x0000, out_ready=1 -> product=0x0000, out_valid rises 6 cycles after acceptance.
REQ-032 Terms 0x0001,0x0002,0x0004,0x0008,0x0010 -> product=0x001F.
REQ-033 Terms 0xFFFF,0x0001,0,0,0 -> product=0x0000; terms 0x8000,0x8000,0,0,0 -> 0x0000 (wrap).
REQ-034 out_ready low 3 cycles in DONE -> out_valid and product held, in_ready=0, new in_valid ignored; accepted the cycle after the handshake.
REQ-035 rst_n pulsed low on 2nd ACCUM cycle -> immediately out_valid=0, busy=0, in_ready=1; no product emitted.
REQ-036 Back-to-back sets 0x0003x5 then 0x0010x5 with in_valid held -> products 0x000F then 0x0050, second accepted 7 cycles after first.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth partial-product accumulator: FSM encoding
// and the derivation of term count, term width and counter width.
package booth_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   // Radix-4 recoding yields one term per two operand bits, plus one extra
   // term for the sign/carry digit.
   localparam int unsigned PP_BITS_PER_TERM   = 2;
   localparam int unsigned PP_EXTRA_TERMS     = 1;
   localparam int unsigned PRODUCT_SCALE      = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Number of partial-product terms for a given operand width.
   function automatic int unsigned calc_num_terms(input int unsigned data_width);
      return data_width / PP_BITS_PER_TERM + PP_EXTRA_TERMS;
   endfunction

   // Width of each term and of the full product.
   function automatic int unsigned calc_term_width(input int unsigned data_width);
      return PRODUCT_SCALE * data_width;
   endfunction

   // Term counter width; one spare bit so the count never wraps before NUM_TERMS.
   function automatic int unsigned calc_cnt_width(input int unsigned num_terms);
      return $clog2(num_terms) + 1;
   endfunction

endpackage

// File: rtl/pp_term_select.sv
// Combinational mux picking term[i_idx] out of the registered term bus.
module pp_term_select
   import booth_pkg::*;
#(
   parameter int unsigned NUM_TERMS  = calc_num_terms(DEFAULT_DATA_WIDTH),
   parameter int unsigned TERM_WIDTH = calc_term_width(DEFAULT_DATA_WIDTH),
   parameter int unsigned CNT_W      = calc_cnt_width(NUM_TERMS)
)(
   input  logic [NUM_TERMS*TERM_WIDTH-1:0] i_terms,
   input  logic [CNT_W-1:0]                i_idx,
   output logic [TERM_WIDTH-1:0]           o_term_c
);

   // Select the indexed term; out-of-range indices return zero.
   always_comb begin
      o_term_c = '0;
      for (int unsigned i = 0; i < NUM_TERMS; i++) begin
         if (i_idx == CNT_W'(i)) begin
            o_term_c = i_terms[i*TERM_WIDTH +: TERM_WIDTH];
         end
      end
   end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator summing Booth partial-product terms one per cycle.
// Timeline for one operation: the accepting cycle, NUM_TERMS ACCUM cycles,
// then DONE, so out_valid appears in cycle NUM_TERMS+1 counting the accepting
// cycle as cycle 0, and a new set can be taken one cycle after the handshake.
module booth_pp_accumulator
   import booth_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned NUM_TERMS  = calc_num_terms(DATA_WIDTH),
   parameter int unsigned TERM_WIDTH = calc_term_width(DATA_WIDTH)
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_TERMS*TERM_WIDTH-1:0] pp_bus,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [TERM_WIDTH-1:0]           product,
   output logic                            busy
);

   localparam int unsigned CNT_W = calc_cnt_width(NUM_TERMS);
   localparam int unsigned BUS_W = NUM_TERMS * TERM_WIDTH;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

   state_t                r_state;
   logic [BUS_W-1:0]      r_terms;
   logic [TERM_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_busy;
   logic [TERM_WIDTH-1:0] w_term;

   pp_term_select #(
      .NUM_TERMS  (NUM_TERMS),
      .TERM_WIDTH (TERM_WIDTH),
      .CNT_W      (CNT_W)
   ) u_term_select (
      .i_terms  (r_terms),
      .i_idx    (r_cnt),
      .o_term_c (w_term)
   );

   // Control FSM, term capture and the single-adder accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_terms     <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_terms    <= pp_bus;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               r_acc <= r_acc + w_term;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_IDX) begin
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign product   = r_acc;

endmodule
